control_unit_mc: RTL and testbench

//  Multi-cycle successor to the single-cycle CPU control unit: decodes INSTRUCTION opcode into registered control

---
 rtl/cpu_ctrl_pkg.sv | 68 ++++++
 rtl/ctrl_decode_rom.sv | 44 ++++
 rtl/control_unit_mc.sv | 169 ++++++++++++++++
 tb/tb_control_unit_mc.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control unit.
// Holds the opcode map, ALU and shifter select encodings, the sequencer
// state type and the control-word struct passed from the decode ROM to
// the control unit's output registers.
package cpu_ctrl_pkg;

  localparam int OPC_BITS = 8;
  localparam int ALU_BITS = 3;

  localparam logic [OPC_BITS-1:0] OP_LOADI = 8'h00;
  localparam logic [OPC_BITS-1:0] OP_MOV   = 8'h01;
  localparam logic [OPC_BITS-1:0] OP_ADD   = 8'h02;
  localparam logic [OPC_BITS-1:0] OP_SUB   = 8'h03;
  localparam logic [OPC_BITS-1:0] OP_AND   = 8'h04;
  localparam logic [OPC_BITS-1:0] OP_OR    = 8'h05;
  localparam logic [OPC_BITS-1:0] OP_J     = 8'h06;
  localparam logic [OPC_BITS-1:0] OP_BEQ   = 8'h07;
  localparam logic [OPC_BITS-1:0] OP_LWD   = 8'h08;
  localparam logic [OPC_BITS-1:0] OP_LWI   = 8'h09;
  localparam logic [OPC_BITS-1:0] OP_SWD   = 8'h0A;
  localparam logic [OPC_BITS-1:0] OP_SWI   = 8'h0B;
  localparam logic [OPC_BITS-1:0] OP_MULT  = 8'h0C;
  localparam logic [OPC_BITS-1:0] OP_SLL   = 8'h0D;
  localparam logic [OPC_BITS-1:0] OP_SRL   = 8'h0E;
  localparam logic [OPC_BITS-1:0] OP_SRA   = 8'h0F;
  localparam logic [OPC_BITS-1:0] OP_ROR   = 8'h10;
  localparam logic [OPC_BITS-1:0] OP_BNE   = 8'h11;

  localparam logic [ALU_BITS-1:0] ALU_FWD   = 3'b000;
  localparam logic [ALU_BITS-1:0] ALU_ADD   = 3'b001;
  localparam logic [ALU_BITS-1:0] ALU_AND   = 3'b010;
  localparam logic [ALU_BITS-1:0] ALU_OR    = 3'b011;
  localparam logic [ALU_BITS-1:0] ALU_MULT  = 3'b100;
  localparam logic [ALU_BITS-1:0] ALU_SHIFT = 3'b101;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_DECODE = 2'd0,
    S_MEM    = 2'd1,
    S_WB     = 2'd2
  } state_t;

  typedef struct packed {
    logic                legal;       // opcode is in the instruction set
    logic                wr_en;
    logic [ALU_BITS-1:0] aluop;
    logic [1:0]          shift_mode;
    logic                complement;
    logic                immediate;
    logic                branch;
    logic                bne;
    logic                jump;
    logic                mem_read;
    logic                mem_write;
    logic                load_word;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

  function automatic logic is_mem_op(input ctrl_word_t w);
    return w.mem_read | w.mem_write;
  endfunction

endpackage

// File: rtl/ctrl_decode_rom.sv
// Combinational opcode -> control word lookup.
// Ports:
//   opcode  in   OPC_W  opcode field of the current instruction
//   word    out  struct control word; CTRL_NOP with legal=0 for unknown opcodes
// Loads and stores come out with wr_en=0: the write-back pulse is produced
// later by the sequencer once memory has answered.
module ctrl_decode_rom
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W = OPC_BITS
) (
  input  logic [OPC_W-1:0] opcode,
  output ctrl_word_t       word
);

  always_comb begin
    // NOTE: assign every field a default before the case so no path leaves
    // a field unassigned, which would infer a latch.
    word       = CTRL_NOP;
    word.legal = 1'b1;
    case (opcode)
      OP_LOADI: begin word.wr_en = 1'b1; word.immediate = 1'b1; end
      OP_MOV:   word.wr_en = 1'b1;
      OP_ADD:   begin word.wr_en = 1'b1; word.aluop = ALU_ADD; end
      OP_SUB:   begin word.wr_en = 1'b1; word.aluop = ALU_ADD; word.complement = 1'b1; end
      OP_AND:   begin word.wr_en = 1'b1; word.aluop = ALU_AND; end
      OP_OR:    begin word.wr_en = 1'b1; word.aluop = ALU_OR; end
      OP_J:     word.jump = 1'b1;
      OP_BEQ:   begin word.aluop = ALU_ADD; word.complement = 1'b1; word.branch = 1'b1; end
      OP_LWD:   word.mem_read = 1'b1;
      OP_LWI:   begin word.mem_read = 1'b1; word.immediate = 1'b1; end
      OP_SWD:   word.mem_write = 1'b1;
      OP_SWI:   begin word.mem_write = 1'b1; word.immediate = 1'b1; end
      OP_MULT:  begin word.wr_en = 1'b1; word.aluop = ALU_MULT; end
      OP_SLL:   begin word.wr_en = 1'b1; word.aluop = ALU_SHIFT; word.shift_mode = SH_SLL; end
      OP_SRL:   begin word.wr_en = 1'b1; word.aluop = ALU_SHIFT; word.shift_mode = SH_SRL; end
      OP_SRA:   begin word.wr_en = 1'b1; word.aluop = ALU_SHIFT; word.shift_mode = SH_SRA; end
      OP_ROR:   begin word.wr_en = 1'b1; word.aluop = ALU_SHIFT; word.shift_mode = SH_ROR; end
      OP_BNE:   begin word.aluop = ALU_ADD; word.complement = 1'b1; word.bne = 1'b1; end
      default:  word.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit_mc.sv
// Multi-cycle CPU control unit: decodes the opcode into registered control
// signals and sequences data-memory loads/stores through the BUSYWAIT
// handshake, aborting an access that stays busy for MEM_TIMEOUT cycles.
// Ports:
//   CLK, RESET        clock; synchronous active-high reset
//   INSTRUCTION       instruction word, opcode in the top OPC_W bits
//   INSTR_VALID       instruction present for decode
//   BUSYWAIT          data memory busy; access complete when low
//   WRITEENABLE ..    registered control word towards the datapath
//   READ / WRITE      data-memory request, held until the access ends
//   PC_STALL          combinational fetch hold
//   MEM_TIMEOUT_ERR   sticky, set when an access times out
//   ILLEGAL_OP        sticky illegal-opcode trap (ILLEGAL_TRAP_EN builds only)
// Configuration: define ILLEGAL_TRAP_EN to trap unknown opcodes; otherwise
// they decode as NOPs.
module control_unit_mc
  import cpu_ctrl_pkg::*;
#(
  parameter int INSTR_W     = 32,
  parameter int OPC_W       = OPC_BITS,
  parameter int ALUOP_W     = ALU_BITS,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [INSTR_W-1:0] INSTRUCTION,
  input  logic               INSTR_VALID,
  input  logic               BUSYWAIT,
  output logic               WRITEENABLE,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic [1:0]         SHIFT_MODE,
  output logic               COMPLEMENT_FLAG,
  output logic               IMMEDIATE_FLAG,
  output logic               BRANCH_FLAG,
  output logic               BNE_FLAG,
  output logic               JUMP_FLAG,
  output logic               READ,
  output logic               WRITE,
  output logic               LOAD_WORD_FLAG,
  output logic               PC_STALL,
  output logic               MEM_TIMEOUT_ERR
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic               ILLEGAL_OP
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state;
  ctrl_word_t       dec_word;   // decode of the live instruction
  ctrl_word_t       op_word;    // memory op latched on entry to S_MEM
  ctrl_word_t       wb_word;
  ctrl_word_t       ctrl_q;     // registered outputs
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             dec_mem;
  logic             mem_done;
  logic             mem_abort;
  logic             timeout_err;
  logic             illegal_stall;
  logic             unused_bits;

  ctrl_decode_rom #(.OPC_W(OPC_W)) u_decode (
    .opcode (INSTRUCTION[INSTR_W-1 -: OPC_W]),
    .word   (dec_word)
  );

`ifdef ILLEGAL_TRAP_EN
  logic trap_q;

  always_ff @(posedge CLK) begin
    if (RESET)
      trap_q <= 1'b0;
    else if (state == S_DECODE && INSTR_VALID && !dec_word.legal)
      trap_q <= 1'b1;
  end

  assign accept        = INSTR_VALID && !trap_q;
  assign illegal_stall = trap_q || (INSTR_VALID && !dec_word.legal);
  assign ILLEGAL_OP    = trap_q;
`else
  assign accept        = INSTR_VALID;
  assign illegal_stall = 1'b0;
`endif

  assign dec_mem  = accept && is_mem_op(dec_word);
  assign cnt_inc  = wait_cnt + 1'b1;
  // The first S_MEM cycle (counter still 0) is when memory latches the
  // request, so BUSYWAIT only counts as completion from the second cycle.
  assign mem_done  = (wait_cnt != '0) && !BUSYWAIT;
  // Abort at the edge where the counter would reach MEM_TIMEOUT; the counter
  // therefore never exceeds MEM_TIMEOUT and cannot wrap.
  assign mem_abort = (cnt_inc == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    wb_word           = op_word;
    wb_word.mem_read  = 1'b0;
    wb_word.wr_en     = 1'b1;
    wb_word.load_word = 1'b1;
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RESET) begin
      state       <= S_DECODE;
      wait_cnt    <= '0;
      op_word     <= CTRL_NOP;
      ctrl_q      <= CTRL_NOP;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_DECODE: begin
          ctrl_q <= accept ? dec_word : CTRL_NOP;
          if (dec_mem) begin
            state    <= S_MEM;
            wait_cnt <= '0;
            op_word  <= dec_word;
          end
        end
        S_MEM: begin
          wait_cnt <= cnt_inc;
          if (mem_done) begin
            if (op_word.mem_read) begin
              state  <= S_WB;
              ctrl_q <= wb_word;
            end else begin
              state  <= S_DECODE;
              ctrl_q <= CTRL_NOP;
            end
          end else if (mem_abort) begin
            state       <= S_DECODE;
            ctrl_q      <= CTRL_NOP;
            timeout_err <= 1'b1;
          end
        end
        S_WB: begin
          state  <= S_DECODE;
          ctrl_q <= CTRL_NOP;
        end
        default: begin
          state  <= S_DECODE;
          ctrl_q <= CTRL_NOP;
        end
      endcase
    end
  end

  assign PC_STALL = !RESET && ((state != S_DECODE) || dec_mem || illegal_stall);

  assign WRITEENABLE     = ctrl_q.wr_en;
  assign ALUOP           = ctrl_q.aluop;
  assign SHIFT_MODE      = ctrl_q.shift_mode;
  assign COMPLEMENT_FLAG = ctrl_q.complement;
  assign IMMEDIATE_FLAG  = ctrl_q.immediate;
  assign BRANCH_FLAG     = ctrl_q.branch;
  assign BNE_FLAG        = ctrl_q.bne;
  assign JUMP_FLAG       = ctrl_q.jump;
  assign READ            = ctrl_q.mem_read;
  assign WRITE           = ctrl_q.mem_write;
  assign LOAD_WORD_FLAG  = ctrl_q.load_word;
  assign MEM_TIMEOUT_ERR = timeout_err;

  // Operand fields are consumed by the datapath, not by this unit.
  assign unused_bits = ^{INSTRUCTION[INSTR_W-OPC_W-1:0], ctrl_q.legal};

endmodule

// File: tb/tb_control_unit_mc.sv
// Self-checking bench for control_unit_mc. A cycle-level reference model
// predicts the registered outputs for the next cycle from each stimulus
// decision; memory accesses are modelled as whole transactions whose length
// follows from the planned BUSYWAIT pattern. One negedge process compares
// every cycle; directed sections add hand-computed literal checks.
module tb_control_unit_mc;

  localparam int TMO = 6;

  typedef struct packed {
    logic       we;
    logic [2:0] aluop;
    logic [1:0] shift;
    logic       comp;
    logic       imm;
    logic       br;
    logic       bne;
    logic       jmp;
    logic       rd;
    logic       wr;
    logic       lwf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic        instr_valid = 1'b0;
  logic        busywait = 1'b0;

  logic       writeenable, complement_flag, immediate_flag, branch_flag;
  logic       bne_flag, jump_flag, mem_read, mem_write, load_word_flag;
  logic       pc_stall, mem_timeout_err;
  logic [2:0] aluop;
  logic [1:0] shift_mode;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  exp_t act, exp_out, pending;
  logic exp_stall = 1'b0, exp_err = 1'b0, err_pending = 1'b0, err_model = 1'b0;
  logic check_en = 1'b0;
  int   total = 0, bad = 0;
  int   rd_cnt = 0, wr_cnt = 0, we_cnt = 0, lwf_cnt = 0;

  logic [7:0] nonmem [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                              8'h07, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11};

  always #5 clk = ~clk;

  control_unit_mc #(.MEM_TIMEOUT(TMO)) dut (
    .CLK             (clk),
    .RESET           (reset),
    .INSTRUCTION     (instruction),
    .INSTR_VALID     (instr_valid),
    .BUSYWAIT        (busywait),
    .WRITEENABLE     (writeenable),
    .ALUOP           (aluop),
    .SHIFT_MODE      (shift_mode),
    .COMPLEMENT_FLAG (complement_flag),
    .IMMEDIATE_FLAG  (immediate_flag),
    .BRANCH_FLAG     (branch_flag),
    .BNE_FLAG        (bne_flag),
    .JUMP_FLAG       (jump_flag),
    .READ            (mem_read),
    .WRITE           (mem_write),
    .LOAD_WORD_FLAG  (load_word_flag),
    .PC_STALL        (pc_stall),
    .MEM_TIMEOUT_ERR (mem_timeout_err)
`ifdef ILLEGAL_TRAP_EN
    ,
    .ILLEGAL_OP      (illegal_op)
`endif
  );

  assign act = {writeenable, aluop, shift_mode, complement_flag, immediate_flag,
                branch_flag, bne_flag, jump_flag, mem_read, mem_write, load_word_flag};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("ctrl_outputs", 32'(act), 32'(exp_out));
      check("pc_stall", 32'(pc_stall), 32'(exp_stall));
      check("timeout_err", 32'(mem_timeout_err), 32'(exp_err));
    end
  end

  // Control word an opcode must produce, straight from the opcode table.
  function automatic exp_t word_of(input logic [7:0] opc);
    exp_t w;
    w = '0;
    w.we   = opc inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0C,
                         8'h0D, 8'h0E, 8'h0F, 8'h10};
    if (opc inside {8'h02, 8'h03, 8'h07, 8'h11}) w.aluop = 3'b001;
    if (opc == 8'h04) w.aluop = 3'b010;
    if (opc == 8'h05) w.aluop = 3'b011;
    if (opc == 8'h0C) w.aluop = 3'b100;
    if (opc inside {[8'h0D:8'h10]}) begin
      w.aluop = 3'b101;
      w.shift = 2'(opc - 8'h0D);
    end
    w.comp = opc inside {8'h03, 8'h07, 8'h11};
    w.imm  = opc inside {8'h00, 8'h09, 8'h0B};
    w.br   = (opc == 8'h07);
    w.bne  = (opc == 8'h11);
    w.jmp  = (opc == 8'h06);
    return w;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [7:0] opc);
    logic [31:0] r;
    r = $urandom();
    return {opc, r[23:0]};
  endfunction

  // Drive one cycle of inputs; nxt is what the outputs must be next cycle.
  task automatic cycle(input logic [31:0] instr, input logic valid, input logic busy,
                       input logic stall, input exp_t nxt);
    exp_out     = pending;
    exp_err     = err_pending;
    exp_stall   = stall;
    instruction = instr;
    instr_valid = valid;
    busywait    = busy;
    pending     = nxt;
    err_pending = err_model;
    @(posedge clk);
    #1;
    if (mem_read)       rd_cnt++;
    if (mem_write)      wr_cnt++;
    if (writeenable)    we_cnt++;
    if (load_word_flag) lwf_cnt++;
  endtask

  task automatic reset_dut(input int n);
    check_en    = 1'b0;
    reset       = 1'b1;
    instr_valid = 1'b0;
    busywait    = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset       = 1'b0;
    pending     = '0;
    exp_out     = '0;
    exp_stall   = 1'b0;
    err_pending = 1'b0;
    err_model   = 1'b0;
    exp_err     = 1'b0;
    check_en    = 1'b1;
  endtask

  task automatic clr_counts();
    rd_cnt = 0; wr_cnt = 0; we_cnt = 0; lwf_cnt = 0;
  endtask

  task automatic idle();
    cycle(mk_instr(8'($urandom)), 1'b0, 1'($urandom), 1'b0, '0);
  endtask

  task automatic issue(input logic [7:0] opc);
    cycle(mk_instr(opc), 1'b1, 1'($urandom), 1'b0, word_of(opc));
  endtask

  // Whole memory transaction. b = cycles BUSYWAIT stays high from the first
  // access cycle. The access ends in the first cycle k>=2 with BUSYWAIT low,
  // or is aborted after TMO cycles if k would exceed TMO.
  task automatic do_mem(input logic [7:0] opc, input int b);
    exp_t memw, wbw;
    int   k, n;
    logic load, aborted;
    load = opc inside {8'h08, 8'h09};
    memw = word_of(opc);
    memw.rd = load;
    memw.wr = !load;
    wbw = word_of(opc);
    wbw.we  = 1'b1;
    wbw.lwf = 1'b1;
    k = (b + 1 < 2) ? 2 : b + 1;
    aborted = (k > TMO);
    n = aborted ? TMO : k;
    cycle(mk_instr(opc), 1'b1, 1'($urandom), 1'b1, memw);
    for (int i = 1; i <= n; i++) begin
      logic busy;
      exp_t nx;
      busy = (i <= b) || (i == 1 && 1'($urandom));
      if (i < n)                  nx = memw;
      else if (!aborted && load)  nx = wbw;
      else                        nx = '0;
      if (aborted && i == n) err_model = 1'b1;
      cycle(mk_instr(8'($urandom)), 1'($urandom), busy, 1'b1, nx);
    end
    if (!aborted && load)
      cycle(mk_instr(8'($urandom)), 1'($urandom), 1'($urandom), 1'b1, '0);
  endtask

  initial begin
    int r;
    pending = '0;
    exp_out = '0;

    reset_dut(2);
    check("reset_outputs", 32'(act), 32'h0);
    check("reset_stall", 32'(pc_stall), 32'h0);

    // add: one-cycle pulse with ALUOP=001, no complement
    issue(8'h02);
    check("add_aluop", 32'(aluop), 32'h1);
    check("add_we", 32'(writeenable), 32'h1);
    check("add_comp", 32'(complement_flag), 32'h0);
    idle();
    check("add_we_pulse", 32'(writeenable), 32'h0);

    issue(8'h0F);
    check("sra_aluop", 32'(aluop), 32'h5);
    check("sra_shift", 32'(shift_mode), 32'h2);
    issue(8'h11);
    check("bne_flag", 32'(bne_flag), 32'h1);
    check("bne_comp", 32'(complement_flag), 32'h1);
    check("bne_we", 32'(writeenable), 32'h0);
    idle();

    // lwd with BUSYWAIT high for 5 cycles
    clr_counts();
    do_mem(8'h08, 5);
    check("lwd_read_cycles", 32'(rd_cnt), 32'd6);
    check("lwd_we_cycles", 32'(we_cnt), 32'd1);
    check("lwd_lwf_cycles", 32'(lwf_cnt), 32'd1);
    idle();

    // swi with BUSYWAIT stuck high -> timeout
    clr_counts();
    do_mem(8'h0B, 1000);
    check("swi_write_cycles", 32'(wr_cnt), 32'(TMO));
    check("swi_no_we", 32'(we_cnt), 32'd0);
    check("swi_timeout_err", 32'(mem_timeout_err), 32'h1);
    idle();

    // completion exactly on the last allowed cycle
    clr_counts();
    do_mem(8'h09, TMO - 1);
    check("lwi_edge_read_cycles", 32'(rd_cnt), 32'(TMO));
    check("lwi_edge_lwf", 32'(lwf_cnt), 32'd1);

    // reset held 2 cycles in the middle of a lwd
    cycle(mk_instr(8'h08), 1'b1, 1'b1, 1'b1, '{rd: 1'b1, default: '0});
    cycle(mk_instr(8'h08), 1'b0, 1'b1, 1'b1, '{rd: 1'b1, default: '0});
    cycle(mk_instr(8'h08), 1'b0, 1'b1, 1'b1, '{rd: 1'b1, default: '0});
    reset_dut(2);
    check("rst_mid_read", 32'(mem_read), 32'h0);
    check("rst_mid_we", 32'(writeenable), 32'h0);
    check("rst_mid_stall", 32'(pc_stall), 32'h0);
    check("rst_mid_err_clear", 32'(mem_timeout_err), 32'h0);
    idle();
    idle();

`ifndef ILLEGAL_TRAP_EN
    cycle(mk_instr(8'hFF), 1'b1, 1'b0, 1'b0, '0);
    check("illegal_nop", 32'(act), 32'h0);
`endif

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 99);
      if (r < 15)
        idle();
      else if (r < 55)
        issue(nonmem[$urandom_range(0, 13)]);
      else if (r < 85)
        do_mem(8'h08 + 8'($urandom_range(0, 3)), $urandom_range(0, TMO + 1));
      else if (r < 94) begin
`ifdef ILLEGAL_TRAP_EN
        idle();
`else
        cycle(mk_instr(8'($urandom_range(8'h12, 8'hFF))), 1'b1, 1'($urandom), 1'b0, '0);
`endif
      end else
        reset_dut($urandom_range(1, 2));
    end

`ifdef ILLEGAL_TRAP_EN
    reset_dut(2);
    cycle(mk_instr(8'hFF), 1'b1, 1'b0, 1'b1, '0);
    check("trap_set", 32'(illegal_op), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cycle(mk_instr(8'h02), 1'b1, 1'b0, 1'b1, '0);
      check("trap_sticky", 32'(illegal_op), 32'h1);
    end
`endif

    idle();
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
